// File: rtl/gate_seq_checker_pkg.sv
// Shared definitions for the gate-bank sequencer: FSM encodings, gate bit
// positions and the golden truth table for the five two-input gates.
package gate_seq_checker_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int GATE_AND  = 0;
  localparam int GATE_OR   = 1;
  localparam int GATE_NOR  = 2;
  localparam int GATE_NAND = 3;
  localparam int GATE_XOR  = 4;

  // Bit order {XOR, NAND, NOR, OR, AND}, indexed by {A,B}
  localparam logic [4:0] GOLDEN_00 = 5'b01100;
  localparam logic [4:0] GOLDEN_01 = 5'b11010;
  localparam logic [4:0] GOLDEN_10 = 5'b11010;
  localparam logic [4:0] GOLDEN_11 = 5'b00011;

  function automatic logic [2:0] popcount5(input logic [4:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/gate_golden.sv
// Expected gate-bank outputs for a given {A,B} vector index.
// Purely combinational, zero latency.
module gate_golden
  import gate_seq_checker_pkg::*;
(
  input  logic [1:0] i_idx,
  output logic [4:0] o_expected
);

  always_comb begin
    o_expected = GOLDEN_00;
    case (i_idx)
      2'd1:    o_expected = GOLDEN_01;
      2'd2:    o_expected = GOLDEN_10;
      2'd3:    o_expected = GOLDEN_11;
      default: o_expected = GOLDEN_00;
    endcase
  end

endmodule

// File: rtl/gate_seq_checker.sv
// Walks the gate bank through AB=00,01,10,11 and checks each sample against the
// golden table; start to done is 4*(SETTLE_CYCLES+2)+1 cycles. GATE_SEQ_ERRCNT_EN adds err_count.
module gate_seq_checker
  import gate_seq_checker_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [4:0] gate_y,
  output logic       vec_a,
  output logic       vec_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       res_valid,
  output logic [4:0] fail_gate,
  output logic [3:0] fail_vec
`ifdef GATE_SEQ_ERRCNT_EN
  ,
  output logic [4:0] err_count
`endif
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_index;
  logic [3:0] r_settle;
  logic [1:0] r_vec;
  logic       r_done;
  logic       r_pass;
  logic       r_res_valid;
  logic [4:0] r_fail_gate;
  logic [3:0] r_fail_vec;

  logic [4:0] w_golden;
  logic [4:0] w_mismatch;
  logic       w_accept;
  logic       w_abort;
  logic       w_busy;

  gate_golden u_golden (
    .i_idx      (r_index),
    .o_expected (w_golden)
  );

  // Case equality so an undriven or X gate output counts as a mismatch
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      w_mismatch[i] = (gate_y[i] === w_golden[i]) ? 1'b0 : 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (start) w_next = S_DRIVE;
        S_DRIVE:  w_next = S_SETTLE;
        S_SETTLE: if (r_settle == 4'd0) w_next = S_SAMPLE;
        S_SAMPLE: w_next = (r_index == 2'd3) ? S_DONE : S_DRIVE;
        S_DONE:   w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy   = (r_state == S_DRIVE) || (r_state == S_SETTLE) || (r_state == S_SAMPLE);
    w_accept = (r_state == S_IDLE) && start && !abort;
    w_abort  = (r_state != S_IDLE) && abort;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_index     <= 2'd0;
      r_settle    <= 4'd0;
      r_vec       <= 2'b00;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_res_valid <= 1'b0;
      r_fail_gate <= 5'd0;
      r_fail_vec  <= 4'd0;
    end else if (w_abort) begin
      r_index     <= 2'd0;
      r_settle    <= 4'd0;
      r_vec       <= 2'b00;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_index     <= 2'd0;
            r_vec       <= 2'b00;
            r_fail_gate <= 5'd0;
            r_fail_vec  <= 4'd0;
            r_res_valid <= 1'b0;
            r_pass      <= 1'b0;
          end
        end
        S_DRIVE:  r_settle <= SETTLE_LOAD;
        S_SETTLE: if (r_settle != 4'd0) r_settle <= r_settle - 4'd1;
        S_SAMPLE: begin
          r_fail_gate         <= r_fail_gate | w_mismatch;
          r_fail_vec[r_index] <= |w_mismatch;
          // Next vector is launched on the same edge so A/B never pass through an intermediate value
          if (r_index != 2'd3) begin
            r_index <= r_index + 2'd1;
            r_vec   <= r_index + 2'd1;
          end
        end
        S_DONE: begin
          r_done      <= 1'b1;
          r_res_valid <= 1'b1;
          r_pass      <= (r_fail_gate == 5'd0);
        end
        default: ;
      endcase
    end
  end

`ifdef GATE_SEQ_ERRCNT_EN
  logic [4:0] r_err_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_count <= 5'd0;
    end else if (w_abort || w_accept) begin
      r_err_count <= 5'd0;
    end else if (r_state == S_SAMPLE) begin
      r_err_count <= r_err_count + {2'b00, popcount5(w_mismatch)};
    end
  end

  assign err_count = r_err_count;
`endif

  assign vec_a     = r_vec[1];
  assign vec_b     = r_vec[0];
  assign busy      = w_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign res_valid = r_res_valid;
  assign fail_gate = r_fail_gate;
  assign fail_vec  = r_fail_vec;

endmodule
